counter_seq_ctrl: RTL and testbench

Sequencing controller for the team's 8-bit counter datapath: owns a loadable down-counter and drives it through load/run/pause/done phases under host control.
- Adds a prescaler, one-shot or auto-reload operation, and a single-cycle terminal-count pulse.
- Sits between control logic (FSMs, CPU-side registers) and anything needing timed events or programmable delays.

---
 rtl/counter_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: load/run/pause/done sequencer around a WIDTH-bit down-counter
// with a programmable prescaler, one-shot or auto-reload operation and a one-cycle
// terminal-count pulse.
// Optional sticky interrupt: define COUNTER_SEQ_CTRL_IRQ_EN to add the irq/irq_clr ports.
module counter_seq_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             irq
`endif
);

  localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_DONE   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             mode_q, mode_d;
  // pend_q: a zero-length start is waiting to emit its done pulse from DONE
  logic             pend_q, pend_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
      mode_q   <= 1'b0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic: stop beats start beats pause; ticks only while running
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    done_d   = 1'b0;

    if (stop) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        count_d = '0;
        pre_d   = '0;
        pend_d  = 1'b0;
      end
    end else if (start) begin
      reload_d = load_val;
      mode_d   = auto_reload;
      count_d  = load_val;
      pre_d    = '0;
      if (load_val == '0) begin
        state_d = S_DONE;
        pend_d  = 1'b1;
      end else begin
        state_d = S_RUN;
        pend_d  = 1'b0;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              done_d = 1'b1;
              if (mode_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = S_DONE;
              end
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        S_PAUSED: begin
          if (!pause) state_d = S_RUN;
        end
        S_DONE: begin
          if (pend_q) begin
            done_d = 1'b1;
            pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

`ifdef COUNTER_SEQ_CTRL_IRQ_EN
  logic irq_q;

  // Sticky interrupt: a new done pulse outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         irq_q <= 1'b0;
    else if (done_d)  irq_q <= 1'b1;
    else if (irq_clr) irq_q <= 1'b0;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: two instances (PRESCALE=1 and PRESCALE=4) share one
// stimulus stream; directed scenarios use hand-derived constants, the random phase
// uses a rule-level reference model. IRQ checks compile when COUNTER_SEQ_CTRL_IRQ_EN is set.
module tb_counter_seq_ctrl;

  logic clk;
  logic rst, start, stop, pause, auto_reload, irq_clr;
  logic [7:0] load_val;
  logic [1:0][7:0] cnt;
  logic [1:0][1:0] st;
  logic [1:0] busy_w, done_w;
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
  logic [1:0] irq_w;
`endif

  int checks = 0;
  int failures = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int m_state[2], m_count[2], m_pre[2], m_reload[2];
  bit m_mode[2], m_done[2], m_pend[2], m_irq[2];

  counter_seq_ctrl #(.WIDTH(8), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .auto_reload(auto_reload), .load_val(load_val),
    .count(cnt[0]), .busy(busy_w[0]), .done(done_w[0]), .state(st[0])
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq_w[0])
`endif
  );

  counter_seq_ctrl #(.WIDTH(8), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .auto_reload(auto_reload), .load_val(load_val),
    .count(cnt[1]), .busy(busy_w[1]), .done(done_w[1]), .state(st[1])
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq_w[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = M_IDLE; m_count[k] = 0; m_pre[k] = 0; m_reload[k] = 0;
      m_mode[k] = 0; m_done[k] = 0; m_pend[k] = 0; m_irq[k] = 0;
    end
  endfunction

  // One clock edge of the specified behaviour, from the inputs sampled at that edge
  function automatic void model_step(int k);
    int p = (k == 0) ? 1 : 4;
    m_done[k] = 0;
    if (stop) begin
      if (m_state[k] != M_IDLE) begin
        m_state[k] = M_IDLE; m_count[k] = 0; m_pre[k] = 0; m_pend[k] = 0;
      end
    end else if (start) begin
      m_reload[k] = int'(load_val); m_mode[k] = auto_reload;
      m_count[k] = int'(load_val); m_pre[k] = 0;
      m_pend[k] = (load_val == 0);
      m_state[k] = (load_val == 0) ? M_DONE : M_RUN;
    end else if (m_state[k] == M_RUN) begin
      if (pause) m_state[k] = M_PAUSED;
      else begin
        m_pre[k] = m_pre[k] + 1;
        if (m_pre[k] == p) begin
          m_pre[k] = 0;
          if (m_count[k] > 1) m_count[k] = m_count[k] - 1;
          else begin
            m_done[k] = 1;
            if (m_mode[k]) m_count[k] = m_reload[k];
            else begin m_count[k] = 0; m_state[k] = M_DONE; end
          end
        end
      end
    end else if (m_state[k] == M_PAUSED) begin
      if (!pause) m_state[k] = M_RUN;
    end else if (m_state[k] == M_DONE && m_pend[k]) begin
      m_done[k] = 1; m_pend[k] = 0;
    end
    if (m_done[k]) m_irq[k] = 1;
    else if (irq_clr) m_irq[k] = 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    if (!rst) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; stop = 1'b0; pause = 1'b0; auto_reload = 1'b0;
    irq_clr = 1'b0; load_val = 8'd5;
    model_reset();
    repeat (3) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({cnt[k], st[k], busy_w[k], done_w[k]} !== {8'd0, 2'b00, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL reset_hold inst=%0d got cnt=%0d st=%0d busy=%0b done=%0b exp 0/0/0/0",
                   k, cnt[k], st[k], busy_w[k], done_w[k]);
        end
      end
    end
    rst = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({cnt[k], st[k], busy_w[k]} !== {8'd5, 2'b01, 1'b1}) begin
        failures++;
        $display("FAIL reset_release_start inst=%0d got cnt=%0d st=%0d busy=%0b exp 5/1/1",
                 k, cnt[k], st[k], busy_w[k]);
      end
    end
  endtask

  task automatic test_async_abort();
    start = 1'b1; load_val = 8'd20; auto_reload = 1'b0;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({cnt[k], st[k], busy_w[k], done_w[k]} !== {8'd0, 2'b00, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL async_abort inst=%0d got cnt=%0d st=%0d busy=%0b done=%0b exp 0/0/0/0",
                 k, cnt[k], st[k], busy_w[k], done_w[k]);
      end
    end
    cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if ({st[0], done_w[0]} !== {2'b00, 1'b0}) begin
      failures++;
      $display("FAIL async_abort_after got st=%0d done=%0b exp 0/0", st[0], done_w[0]);
    end
  endtask

  task automatic test_oneshot();
    start = 1'b1; load_val = 8'd5; auto_reload = 1'b0;
    cyc();
    start = 1'b0;
    checks++;
    if ({cnt[0], st[0], busy_w[0], done_w[0]} !== {8'd5, 2'b01, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL oneshot_start got cnt=%0d st=%0d busy=%0b done=%0b exp 5/1/1/0",
               cnt[0], st[0], busy_w[0], done_w[0]);
    end
    for (int v = 4; v >= 0; v--) begin
      cyc();
      checks++;
      if ({cnt[0], done_w[0]} !== {8'(v), v == 0}) begin
        failures++;
        $display("FAIL oneshot_seq got cnt=%0d done=%0b exp cnt=%0d done=%0b",
                 cnt[0], done_w[0], v, v == 0);
      end
    end
    checks++;
    if ({st[0], busy_w[0]} !== {2'b11, 1'b0}) begin
      failures++;
      $display("FAIL oneshot_done_state got st=%0d busy=%0b exp 3/0", st[0], busy_w[0]);
    end
    repeat (10) begin
      cyc();
      checks++;
      if ({cnt[0], st[0], done_w[0]} !== {8'd0, 2'b11, 1'b0}) begin
        failures++;
        $display("FAIL oneshot_hold got cnt=%0d st=%0d done=%0b exp 0/3/0",
                 cnt[0], st[0], done_w[0]);
      end
    end
  endtask

  task automatic test_autoreload();
    int pulses = 0;
    stop = 1'b1; cyc(); stop = 1'b0;
    start = 1'b1; load_val = 8'd3; auto_reload = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (cnt[1] !== 8'd3) begin
      failures++;
      $display("FAIL autoreload_start got cnt=%0d exp 3", cnt[1]);
    end
    for (int n = 1; n <= 36; n++) begin
      cyc();
      if (done_w[1] === 1'b1) pulses++;
      checks++;
      if ({cnt[1], done_w[1], busy_w[1]} !== {8'(3 - ((n / 4) % 3)), (n % 12) == 0, 1'b1}) begin
        failures++;
        $display("FAIL autoreload n=%0d got cnt=%0d done=%0b busy=%0b exp cnt=%0d done=%0b busy=1",
                 n, cnt[1], done_w[1], busy_w[1], 3 - ((n / 4) % 3), (n % 12) == 0);
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL autoreload_pulses got %0d exp 3", pulses);
    end
  endtask

  task automatic test_pause_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
    start = 1'b1; load_val = 8'd10; auto_reload = 1'b0;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    checks++;
    if (cnt[0] !== 8'd7) begin
      failures++;
      $display("FAIL pause_pre got cnt=%0d exp 7", cnt[0]);
    end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if ({cnt[0], st[0], busy_w[0]} !== {8'd7, 2'b10, 1'b1}) begin
        failures++;
        $display("FAIL paused i=%0d got cnt=%0d st=%0d busy=%0b exp 7/2/1",
                 i, cnt[0], st[0], busy_w[0]);
      end
    end
    pause = 1'b0;
    cyc();
    checks++;
    if ({cnt[0], st[0]} !== {8'd7, 2'b01}) begin
      failures++;
      $display("FAIL resume_edge got cnt=%0d st=%0d exp 7/1", cnt[0], st[0]);
    end
    for (int v = 6; v >= 4; v--) begin
      cyc();
      checks++;
      if ({cnt[0], done_w[0]} !== {8'(v), 1'b0}) begin
        failures++;
        $display("FAIL resumed got cnt=%0d done=%0b exp %0d/0", cnt[0], done_w[0], v);
      end
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if ({cnt[0], st[0], busy_w[0], done_w[0]} !== {8'd0, 2'b00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stop got cnt=%0d st=%0d busy=%0b done=%0b exp 0/0/0/0",
               cnt[0], st[0], busy_w[0], done_w[0]);
    end
  endtask

  task automatic test_edges();
    start = 1'b1; load_val = 8'd0; auto_reload = 1'b0;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({cnt[k], st[k], busy_w[k], done_w[k]} !== {8'd0, 2'b11, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL zero_load inst=%0d got cnt=%0d st=%0d busy=%0b done=%0b exp 0/3/0/0",
                 k, cnt[k], st[k], busy_w[k], done_w[k]);
      end
    end
    for (int e = 0; e < 2; e++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (done_w[k] !== (e == 0)) begin
          failures++;
          $display("FAIL zero_load_pulse inst=%0d e=%0d got done=%0b exp %0b",
                   k, e, done_w[k], e == 0);
        end
      end
    end
    start = 1'b1; load_val = 8'd9;
    cyc();
    stop = 1'b1; load_val = 8'd4;
    cyc();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({cnt[0], st[0], busy_w[0]} !== {8'd0, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL start_stop got cnt=%0d st=%0d busy=%0b exp 0/0/0", cnt[0], st[0], busy_w[0]);
    end
    start = 1'b1; load_val = 8'd5;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    checks++;
    if (cnt[0] !== 8'd2) begin
      failures++;
      $display("FAIL restart_pre got cnt=%0d exp 2", cnt[0]);
    end
    start = 1'b1; load_val = 8'd9;
    cyc();
    start = 1'b0;
    checks++;
    if ({cnt[0], st[0], done_w[0]} !== {8'd9, 2'b01, 1'b0}) begin
      failures++;
      $display("FAIL restart got cnt=%0d st=%0d done=%0b exp 9/1/0", cnt[0], st[0], done_w[0]);
    end
  endtask

`ifdef COUNTER_SEQ_CTRL_IRQ_EN
  task automatic test_irq();
    stop = 1'b1; irq_clr = 1'b1; cyc(); stop = 1'b0; irq_clr = 1'b0;
    checks++;
    if (irq_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL irq_initial got %0b exp 0", irq_w[0]);
    end
    start = 1'b1; load_val = 8'd2; auto_reload = 1'b0;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (irq_w[0] !== 1'b1) begin
        failures++;
        $display("FAIL irq_sticky i=%0d got %0b exp 1", i, irq_w[0]);
      end
      cyc();
    end
    start = 1'b1; auto_reload = 1'b1;
    cyc();
    start = 1'b0; irq_clr = 1'b1;
    cyc();
    checks++;
    if (irq_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear got %0b exp 0", irq_w[0]);
    end
    cyc();
    checks++;
    if ({done_w[0], irq_w[0]} !== 2'b11) begin
      failures++;
      $display("FAIL irq_set_wins got done=%0b irq=%0b exp 1/1", done_w[0], irq_w[0]);
    end
    cyc();
    irq_clr = 1'b0;
    checks++;
    if (irq_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL irq_clear_alone got %0b exp 0", irq_w[0]);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst         = ($urandom_range(0, 199) != 0);
      stop        = ($urandom_range(0, 99) < 4);
      start       = ($urandom_range(0, 99) < 7);
      if ($urandom_range(0, 99) < 15) pause = ~pause;
      auto_reload = $urandom_range(0, 1) == 1;
      irq_clr     = ($urandom_range(0, 99) < 10);
      load_val    = 8'($urandom_range(0, 12));
      cyc();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({cnt[k], st[k], busy_w[k], done_w[k]} !==
            {8'(m_count[k]), 2'(m_state[k]), m_state[k] == M_RUN || m_state[k] == M_PAUSED, m_done[k]}) begin
          failures++;
          $display("FAIL random c=%0d inst=%0d got cnt=%0d st=%0d busy=%0b done=%0b exp cnt=%0d st=%0d done=%0b",
                   c, k, cnt[k], st[k], busy_w[k], done_w[k], m_count[k], m_state[k], m_done[k]);
        end
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
        checks++;
        if (irq_w[k] !== m_irq[k]) begin
          failures++;
          $display("FAIL random_irq c=%0d inst=%0d got %0b exp %0b", c, k, irq_w[k], m_irq[k]);
        end
`endif
      end
    end
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; irq_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_async_abort();
    test_oneshot();
    test_autoreload();
    test_pause_stop();
    test_edges();
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
